// File: rtl/loader_pkg.sv
// Shared types and defaults for the serial instruction loader.
package loader_pkg;
  localparam int         ADDR_W         = 6;
  localparam int         MAX_WORDS_DEF  = 64;
  localparam logic [7:0] START_BYTE_DEF = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_e;
endpackage

// File: rtl/byte_packer.sv
// Assembles four accepted bytes big-endian into a 32-bit word and pulses when a word is complete.
module byte_packer (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o,
  output logic        word_vld_o
);
  logic [1:0]  idx_p0;
  logic [23:0] part_p0;
  logic [31:0] word_p1;
  logic        vld_p1;

  assign last_o     = accept_i && (idx_p0 == 2'd3);
  assign word_o     = word_p1;
  assign word_vld_o = vld_p1;

  // stage p0 -> p1: byte accumulation, completed word registered with its strobe
  always_ff @(posedge clk_i) begin
    if (reset) begin
      idx_p0  <= 2'd0;
      part_p0 <= 24'd0;
      word_p1 <= 32'd0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= last_o;
      if (accept_i) begin
        idx_p0 <= idx_p0 + 2'd1;
        if (last_o) begin
          word_p1 <= {part_p0, byte_i};
        end else begin
          part_p0 <= {part_p0[15:0], byte_i};
        end
      end
    end
  end
endmodule

// File: rtl/instr_loader.sv
// Receives a framed byte stream (start marker, word count, payload) and writes it into instruction memory.
module instr_loader
  import loader_pkg::*;
#(
  parameter int         MAX_WORDS  = MAX_WORDS_DEF,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              err_o,
  output logic [6:0]        word_cnt_o
);
  localparam logic [7:0] MAX_B = 8'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [6:0]        n_q;
  logic [6:0]        cnt_q;
  logic [6:0]        cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              last_byte;
  logic              is_start;

  assign accept   = byte_valid_i && (state_q == ST_LOAD);
  assign is_start = byte_valid_i && (byte_i == START_BYTE);
  assign cnt_inc  = cnt_q + 7'd1;

  byte_packer u_packer (
    .clk_i      (clk_i),
    .reset      (reset),
    .accept_i   (accept),
    .byte_i     (byte_i),
    .last_o     (last_byte),
    .word_o     (imem_data_o),
    .word_vld_o (imem_we_o)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (is_start) state_d = ST_HEADER;
      ST_HEADER: if (byte_valid_i) begin
        state_d = ((byte_i == 8'd0) || (byte_i > MAX_B)) ? ST_ERR : ST_LOAD;
      end
      ST_LOAD:   if (last_byte && (cnt_inc == n_q)) state_d = ST_DONE;
      ST_DONE:   if (is_start) state_d = ST_HEADER;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
  end

  // counters update on the same edge that registers the word, so the strobe and count appear together
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_q     <= 7'd0;
      cnt_q   <= 7'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_HEADER && byte_valid_i) n_q <= byte_i[6:0];
      if (last_byte) begin
        cnt_q  <= cnt_inc;
        addr_q <= cnt_q[ADDR_W-1:0];
      end else if (state_q == ST_DONE && is_start) begin
        cnt_q <= 7'd0;
      end
    end
  end

  assign imem_addr_o = addr_q;
  assign word_cnt_o  = cnt_q;
  assign load_done_o = (state_q == ST_DONE);
  assign cpu_rst_o   = (state_q != ST_DONE);
  assign err_o       = (state_q == ST_ERR);
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: cycle-by-cycle vector table plus a back-to-back multi-word frame.
module tb_instr_loader;
  logic        clk_i = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        imem_we_o;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        cpu_rst_o;
  logic        load_done_o;
  logic        err_o;
  logic [6:0]  word_cnt_o;

  int checks = 0;
  int errors = 0;

  instr_loader dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .cpu_rst_o    (cpu_rst_o),
    .load_done_o  (load_done_o),
    .err_o        (err_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  b;
    logic        we;
    logic        ad;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        crst;
    logic        done;
    logic        err;
    logic [6:0]  cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic v, input logic [7:0] b,
                     input logic we, input logic ad, input logic [5:0] addr,
                     input logic [31:0] data, input logic crst, input logic done,
                     input logic err, input logic [6:0] cnt);
    vec_t e;
    e.rst = rst; e.v = v; e.b = b; e.we = we; e.ad = ad; e.addr = addr;
    e.data = data; e.crst = crst; e.done = done; e.err = err; e.cnt = cnt;
    tv.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input logic [7:0] b);
    reset = rst;
    byte_valid_i = v;
    byte_i = b;
    @(posedge clk_i);
    #1;
  endtask

  // loading/header cycles before any word completes: CPU held, nothing done
  task automatic hold(input logic [7:0] b);
    add(0, 1, b, 0, 0, 6'd0, 32'd0, 1, 0, 0, 7'd0);
  endtask

  task automatic in_err(input logic [7:0] b);
    add(0, 1, b, 0, 0, 6'd0, 32'd0, 1, 0, 1, 7'd0);
  endtask

  task automatic do_reset();
    add(1, 0, 8'h00, 0, 1, 6'd0, 32'd0, 1, 0, 0, 7'd0);
  endtask

  logic [7:0] pl [12];

  initial begin
    // reset wins over a simultaneous start byte
    add(1, 1, 8'hFE, 0, 1, 6'd0, 32'd0, 1, 0, 0, 7'd0);
    // single-word frame
    hold(8'hFE); hold(8'h01); hold(8'h00); hold(8'h50); hold(8'h00);
    add(0, 1, 8'h93, 1, 1, 6'd0, 32'h00500093, 0, 1, 0, 7'd1);
    add(0, 0, 8'hFE, 0, 1, 6'd0, 32'h00500093, 0, 1, 0, 7'd1);
    add(0, 1, 8'h55, 0, 0, 6'd0, 32'd0,        0, 1, 0, 7'd1);
    // reload from DONE
    hold(8'hFE); hold(8'h01); hold(8'h12); hold(8'h34); hold(8'h56);
    add(0, 1, 8'h78, 1, 1, 6'd0, 32'h12345678, 0, 1, 0, 7'd1);
    // two words with a 3-cycle gap inside the first word
    hold(8'hFE); hold(8'h02); hold(8'h11); hold(8'h22);
    add(0, 0, 8'hFE, 0, 0, 6'd0, 32'd0, 1, 0, 0, 7'd0);
    add(0, 0, 8'h00, 0, 0, 6'd0, 32'd0, 1, 0, 0, 7'd0);
    add(0, 0, 8'hFE, 0, 0, 6'd0, 32'd0, 1, 0, 0, 7'd0);
    hold(8'h33);
    add(0, 1, 8'h44, 1, 1, 6'd0, 32'h11223344, 1, 0, 0, 7'd1);
    add(0, 1, 8'h55, 0, 0, 6'd0, 32'd0, 1, 0, 0, 7'd1);
    add(0, 1, 8'h66, 0, 0, 6'd0, 32'd0, 1, 0, 0, 7'd1);
    add(0, 1, 8'h77, 0, 0, 6'd0, 32'd0, 1, 0, 0, 7'd1);
    add(0, 1, 8'h88, 1, 1, 6'd1, 32'h55667788, 0, 1, 0, 7'd2);
    // reset mid-word discards the partial word
    hold(8'hFE); hold(8'h02); hold(8'hAA); hold(8'hBB); hold(8'hFE);
    add(1, 1, 8'hCC, 0, 1, 6'd0, 32'd0, 1, 0, 0, 7'd0);
    add(0, 0, 8'h00, 0, 1, 6'd0, 32'd0, 1, 0, 0, 7'd0);
    hold(8'hFE); hold(8'h01); hold(8'hFE); hold(8'hFE); hold(8'hFE);
    add(0, 1, 8'hFE, 1, 1, 6'd0, 32'hFEFEFEFE, 0, 1, 0, 7'd1);
    // N=0 is illegal and sticky until reset
    hold(8'hFE);
    in_err(8'h00); in_err(8'hFE); in_err(8'h01);
    in_err(8'hFE); in_err(8'hFE); in_err(8'hFE); in_err(8'hFE);
    do_reset();
    // N=65 is illegal
    hold(8'hFE);
    in_err(8'h41); in_err(8'h00); in_err(8'h50); in_err(8'h00); in_err(8'h93);
    do_reset();
    // N=64 is the largest legal count
    hold(8'hFE); hold(8'h40); hold(8'hDE); hold(8'hAD); hold(8'hBE);
    add(0, 1, 8'hEF, 1, 1, 6'd0, 32'hDEADBEEF, 1, 0, 0, 7'd1);
    do_reset();

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rst, tv[i].v, tv[i].b);
      chk($sformatf("v%0d.we", i),   {31'd0, imem_we_o},   {31'd0, tv[i].we});
      chk($sformatf("v%0d.crst", i), {31'd0, cpu_rst_o},   {31'd0, tv[i].crst});
      chk($sformatf("v%0d.done", i), {31'd0, load_done_o}, {31'd0, tv[i].done});
      chk($sformatf("v%0d.err", i),  {31'd0, err_o},       {31'd0, tv[i].err});
      chk($sformatf("v%0d.cnt", i),  {25'd0, word_cnt_o},  {25'd0, tv[i].cnt});
      if (tv[i].ad) begin
        chk($sformatf("v%0d.addr", i), {26'd0, imem_addr_o}, {26'd0, tv[i].addr});
        chk($sformatf("v%0d.data", i), imem_data_o, tv[i].data);
      end
    end

    // back-to-back three-word frame: strobe exactly on each word boundary
    for (int i = 0; i < 12; i++) pl[i] = 8'(8'h10 + i * 8'h13);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hFE);
    cyc(0, 1, 8'h03);
    chk("b2b.hdr_we", {31'd0, imem_we_o}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, pl[i]);
      if (i % 4 == 3) begin
        chk($sformatf("b2b.we%0d", i), {31'd0, imem_we_o}, 32'd1);
        chk($sformatf("b2b.addr%0d", i), {26'd0, imem_addr_o}, 32'(i / 4));
        chk($sformatf("b2b.data%0d", i), imem_data_o,
            {pl[i-3], pl[i-2], pl[i-1], pl[i]});
      end else begin
        chk($sformatf("b2b.we%0d", i), {31'd0, imem_we_o}, 32'd0);
      end
      chk($sformatf("b2b.cnt%0d", i), {25'd0, word_cnt_o}, 32'((i + 1) / 4));
      chk($sformatf("b2b.done%0d", i), {31'd0, load_done_o}, {31'd0, i == 11});
    end
    cyc(0, 1, 8'h00);
    chk("b2b.after_we", {31'd0, imem_we_o}, 32'd0);
    chk("b2b.after_crst", {31'd0, cpu_rst_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64, instruction-memory depth in 32-bit words.
REQ-002 Parameter START_BYTE, default 8'hFE, frame-start marker.
REQ-003 Port clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port byte_valid_i  input  1  byte_i is valid this cycle.
REQ-006 Port byte_i  input  8  serial instruction byte stream.
REQ-007 Port imem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-008 Port imem_addr_o  output  6  word address for the write.
REQ-009 Port imem_data_o  output  32  assembled instruction word.
REQ-010 Port cpu_rst_o  output  1  holds the downstream CPU in reset while a program is not loaded.
REQ-011 Port load_done_o  output  1  level; program fully loaded.
REQ-012 Port err_o  output  1  level; illegal frame header.
REQ-013 Port word_cnt_o  output  7  words written so far in the current frame.

Function
REQ-014 States SHALL be IDLE, HEADER, LOAD, DONE and ERR.
REQ-015 IDLE: a valid byte equal to START_BYTE -> HEADER; all other bytes ignored.
REQ-016 HEADER: the next valid byte is the word count N; N in 1..MAX_WORDS -> LOAD with N latched; N=0 or N>MAX_WORDS -> ERR.
REQ-017 LOAD: valid bytes are packed big-endian (1st byte -> [31:24], 4th byte -> [7:0]); START_BYTE values are treated as data.
REQ-018 On the cycle after the 4th byte of a word is accepted, imem_we_o SHALL be 1 for exactly one cycle, with imem_addr_o = word index (0-based) and imem_data_o = packed word.
REQ-019 word_cnt_o SHALL increment in the same cycle imem_we_o is high.
REQ-020 After the write of word N-1: LOAD -> DONE; load_done_o rises in that cycle; cpu_rst_o falls in the same cycle.
REQ-021 Invalid cycles (byte_valid_i=0) in any state SHALL hold all state, byte index and partial word; gaps inside a word are legal.
REQ-022 DONE: a valid START_BYTE -> HEADER, with load_done_o cleared, cpu_rst_o set and word_cnt_o cleared in the same cycle; other bytes are ignored.
REQ-023 ERR: err_o=1 and cpu_rst_o=1; the block leaves ERR only on reset.
REQ-024 imem_we_o SHALL never be high outside the LOAD->write sequence; at most one write per cycle.
REQ-025 imem_addr_o and imem_data_o are don't-care when imem_we_o=0 but SHALL hold their last written values.
REQ-026 Bytes arriving on every cycle (back-to-back) SHALL be accepted with no loss; the write of word k overlaps acceptance of byte 0 of word k+1.

Reset
REQ-027 When reset=1 at a clock edge: state=IDLE; byte index, N, word_cnt_o and partial word = 0; imem_we_o=0; imem_addr_o=0; imem_data_o=0; load_done_o=0; err_o=0; cpu_rst_o=1.
REQ-028 Reset mid-LOAD SHALL discard the partial word with no write in the following cycle; words already written remain in memory.
REQ-029 Reset has priority over a simultaneous valid byte.

Structure
REQ-030 Package loader_pkg SHALL hold the state enum, START_BYTE default, MAX_WORDS default and the address width (6).
REQ-031 One sub-module, byte_packer (4-byte shift/assemble register with byte index and word-ready pulse), is natural; the FSM and counters live in instr_loader.

Verification
REQ-032 Reset, then bytes FE,01,00,50,00,93 back-to-back -> one imem_we_o pulse, addr 0, data 32'h00500093; load_done_o=1 and cpu_rst_o=0 in that cycle; word_cnt_o=1.
REQ-033 FE,02 + 8 data bytes, with byte_valid_i low for 3 cycles between bytes 2 and 3 -> writes at addr 0 and addr 1 with correct words; no extra or early strobes.
REQ-034 FE,00 -> err_o=1, cpu_rst_o=1; later FE bytes ignored; reset clears err_o.
REQ-035 FE,41 (N=65) -> ERR; no writes.
REQ-036 FE,02,AA,BB,FE then reset, then FE,01,FE,FE,FE,FE -> no write from the first frame; second frame writes addr 0 data 32'hFEFEFEFE.
REQ-037 After DONE, send FE,01,12,34,56,78 -> cpu_rst_o and load_done_o toggle as specified; addr 0 is rewritten with 32'h12345678.
